ro_sample_ctrl: RTL and testbench
=================================

Name: ro_sample_ctrl

Overview:
- Sequences the ring-oscillator power-sensor array through repeated measurement windows: clear, enable for a programmed number of clocks, disable, settle, capture.
- Each captured 36-bit sum goes into an internal FIFO and out on a valid/ready stream to the readout/UART logic.
- Sits between the system clock domain and the sensor array; it is the only driver of the array's enable and reset.

Parameters:
- WIN_W, 16, width of window_len.
- CLR_CYCLES, 4, clocks ro_reset is held in CLEAR (>=1).
- SETTLE_CYCLES, 4, clocks after enable falls before monitor_count is sampled (>=2, covers the array's async capture on enable falling edge).
- DEPTH, 8, FIFO entries (power of 2, >=2).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins a run when IDLE.
- stop  in  1  pulse; ends run after the current window.
- continuous  in  1  1 = run until stop; 0 = run num_samples windows. Sampled at start.
- window_len  in  WIN_W  enable-window length in clocks. Sampled at start.
- num_samples  in  16  windows per run when continuous=0. Sampled at start.
- ro_enable  out  1  array enable.
- ro_reset  out  1  array reset, active-high.
- monitor_count  in  36  array latched sum.
- sample_data  out  36  FIFO head.
- sample_valid  out  1  FIFO not empty.
- sample_ready  in  1  consumer accept.
- busy  out  1  state != IDLE.
- overflow  out  1  sticky; a capture was dropped.
- fifo_level  out  clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset values:
  - ro_enable=0, ro_reset=1, busy=0, overflow=0, sample_valid=0, fifo_level=0, sample_data=0.
  - State IDLE, FIFO empty, internal counters 0.
- All outputs are registered.
- FSM:
  - IDLE: ro_reset=1, ro_enable=0.
    - start=1 with stop=0: latch config, clear sample counter, clear overflow, go to CLEAR.
    - start and stop in the same cycle: stay IDLE.
  - CLEAR: ro_reset=1, ro_enable=0 for exactly CLR_CYCLES clocks, then MEASURE.
  - MEASURE: ro_reset=0, ro_enable=1 for exactly max(window_len,1) clocks, then SETTLE.
  - SETTLE: ro_reset=0, ro_enable=0 for SETTLE_CYCLES clocks, then CAPTURE.
  - CAPTURE, one clock:
    - Push monitor_count into the FIFO and increment the sample counter.
    - Go to IDLE if stop_pend=1, or if continuous=0 and counter == max(num_samples,1). Otherwise go to CLEAR.
- stop:
  - Any stop pulse while busy sets stop_pend.
  - stop_pend is honoured only in CAPTURE, so the current window always completes and is captured.
  - stop_pend clears on entry to IDLE.
  - stop in IDLE is ignored.
- start while busy is ignored.
- Config inputs changing mid-run have no effect.
- Window period: CLR_CYCLES + max(window_len,1) + SETTLE_CYCLES + 1 clocks.
- FIFO:
  - First-word-fall-through. sample_data is valid in the same cycle sample_valid=1.
  - Pop when sample_valid & sample_ready.
  - Push when full without a simultaneous pop: sample dropped, overflow=1 sticky, FIFO contents unchanged.
  - Push when full with a simultaneous pop: accepted, no overflow, level unchanged.
  - Push when empty with sample_ready=1: the entry is visible next cycle; no same-cycle bypass.
  - sample_data holds its last value when empty.
  - overflow clears only on reset or on an accepted start.
  - The FIFO is not flushed by start.
- Counters: the window counter is WIN_W bits; the sample counter is 16 bits and saturates at 0xFFFF in continuous mode (does not wrap).
- reset_n asserted mid-run: immediate return to reset values, FIFO emptied, ro_enable drops asynchronously.

Test Plan:
- Reset, then start with continuous=0, num_samples=3, window_len=10, monitor_count driven to 100/200/300 during successive SETTLE phases -> ro_enable high exactly 10 clocks per window; period 19 clocks; FIFO pops 100, 200, 300; busy falls after the third CAPTURE.
- window_len=0, num_samples=0 -> exactly one window with ro_enable high 1 clock; one sample captured.
- continuous=1, stop pulsed mid-MEASURE of the 5th window -> the 5th window completes, 5 samples total, IDLE after that CAPTURE.
- sample_ready=0, DEPTH=8, continuous run of 10 windows -> fifo_level saturates at 8, overflow=1 at the 9th capture; first 8 values are preserved in order.
- FIFO full with sample_ready=1 during CAPTURE -> new sample accepted, overflow stays 0, fifo_level stays 8.
- reset_n low during MEASURE -> ro_enable=0 and ro_reset=1 immediately, fifo_level=0, busy=0; start after release runs normally.

Source files
------------

// File: rtl/ro_sample_ctrl.sv
// Ring-oscillator sensor sequencer: clear / enable window / settle / capture,
// with captured sums queued in a first-word-fall-through FIFO.
module ro_sample_ctrl #(
    parameter int unsigned WIN_W         = 16,
    parameter int unsigned CLR_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned DEPTH         = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         stop,
    input  logic                         continuous,
    input  logic [WIN_W-1:0]             window_len,
    input  logic [15:0]                  num_samples,
    output logic                         ro_enable,
    output logic                         ro_reset,
    input  logic [35:0]                  monitor_count,
    output logic [35:0]                  sample_data,
    output logic                         sample_valid,
    input  logic                         sample_ready,
    output logic                         busy,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
    localparam int unsigned DATA_W = 36;
    localparam int unsigned SAMP_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_MEASURE,
        S_SETTLE,
        S_CAPTURE
    } state_t;

    state_t              state_q, state_d;
    logic [WIN_W-1:0]    cnt_q, cnt_d, win_q;
    logic [SAMP_W-1:0]   samp_q, nsamp_q, samp_inc;
    logic                cont_q, stop_pend_q;
    logic                run_start, capture;
    logic                en_d, rst_d, busy_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0]    level_d;
    logic [DATA_W-1:0]   head_d;
    logic                full, pop, push_ok, drop;

    assign run_start = (state_q == S_IDLE) && start && !stop;
    assign capture   = (state_q == S_CAPTURE);
    assign samp_inc  = (samp_q == '1) ? samp_q : samp_q + SAMP_W'(1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next state, phase counter and array control levels for the next cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + WIN_W'(1);
        en_d    = 1'b0;
        rst_d   = 1'b0;
        busy_d  = 1'b1;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (run_start) state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (cnt_q == WIN_W'(CLR_CYCLES - 1)) begin
                    state_d = S_MEASURE;
                    cnt_d   = '0;
                end
            end
            S_MEASURE: begin
                if (cnt_q == win_q - WIN_W'(1)) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end
            end
            S_SETTLE: begin
                if (cnt_q == WIN_W'(SETTLE_CYCLES - 1)) begin
                    state_d = S_CAPTURE;
                    cnt_d   = '0;
                end
            end
            S_CAPTURE: begin
                cnt_d = '0;
                if (stop_pend_q || (!cont_q && samp_inc == nsamp_q)) state_d = S_IDLE;
                else                                                  state_d = S_CLEAR;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        en_d   = (state_d == S_MEASURE);
        rst_d  = (state_d == S_IDLE) || (state_d == S_CLEAR);
        busy_d = (state_d != S_IDLE);
    end

    // Run configuration, counters and registered control outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            win_q       <= '0;
            nsamp_q     <= '0;
            samp_q      <= '0;
            cont_q      <= 1'b0;
            stop_pend_q <= 1'b0;
            ro_enable   <= 1'b0;
            ro_reset    <= 1'b1;
            busy        <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            ro_enable <= en_d;
            ro_reset  <= rst_d;
            busy      <= busy_d;
            if (run_start) begin
                win_q   <= (window_len == '0) ? WIN_W'(1) : window_len;
                nsamp_q <= (num_samples == '0) ? SAMP_W'(1) : num_samples;
                cont_q  <= continuous;
                samp_q  <= '0;
            end else if (capture) begin
                samp_q <= samp_inc;
            end
            if (state_d == S_IDLE)               stop_pend_q <= 1'b0;
            else if (stop && state_q != S_IDLE)  stop_pend_q <= 1'b1;
        end
    end

    assign full    = (fifo_level == LVL_W'(DEPTH));
    assign pop     = sample_valid && sample_ready;
    assign push_ok = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    // Next occupancy and next head word; the head register keeps its value when empty.
    always_comb begin
        level_d = fifo_level;
        head_d  = sample_data;
        case ({push_ok, pop})
            2'b10:   level_d = fifo_level + LVL_W'(1);
            2'b01:   level_d = fifo_level - LVL_W'(1);
            default: level_d = fifo_level;
        endcase
        if (pop) begin
            if (fifo_level == LVL_W'(1)) begin
                if (push_ok) head_d = monitor_count;
            end else begin
                head_d = mem[rd_ptr + PTR_W'(1)];
            end
        end else if (fifo_level == '0 && push_ok) begin
            head_d = monitor_count;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= monitor_count;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            sample_valid <= 1'b0;
            sample_data  <= '0;
            overflow     <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level   <= level_d;
            sample_valid <= (level_d != '0);
            sample_data  <= head_d;
            if (run_start) overflow <= 1'b0;
            else if (drop) overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ro_sample_ctrl.sv
// Directed bench for ro_sample_ctrl: window timing, sample counts, FIFO order,
// overflow behaviour and asynchronous reset, with a queue-based scoreboard.
module tb_ro_sample_ctrl;

    localparam int unsigned WIN_W = 16;
    localparam int unsigned DEPTH = 8;

    logic              clk          = 1'b0;
    logic              reset_n      = 1'b0;
    logic              start        = 1'b0;
    logic              stop         = 1'b0;
    logic              continuous   = 1'b0;
    logic [WIN_W-1:0]  window_len   = '0;
    logic [15:0]       num_samples  = '0;
    logic [35:0]       monitor_count = '0;
    logic              sample_ready = 1'b0;
    logic              ro_enable, ro_reset, sample_valid, busy, overflow;
    logic [35:0]       sample_data;
    logic [$clog2(DEPTH+1)-1:0] fifo_level;

    ro_sample_ctrl #(
        .WIN_W(WIN_W), .CLR_CYCLES(4), .SETTLE_CYCLES(4), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .stop(stop),
        .continuous(continuous), .window_len(window_len), .num_samples(num_samples),
        .ro_enable(ro_enable), .ro_reset(ro_reset), .monitor_count(monitor_count),
        .sample_data(sample_data), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .busy(busy), .overflow(overflow), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [35:0] exp_q[$];
    int          hi_q[$];
    int          rise_q[$];
    int          cyc     = 0;
    int          hi_run  = 0;
    int          win_idx = 0;
    int          n_pop   = 0;
    logic        en_prev = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // Scoreboard pop on the handshake about to be taken, then advance one clock and
    // track enable windows; each window's sum is presented once enable falls.
    task automatic tick();
        logic [35:0] e;
        if (sample_valid && sample_ready) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 64'(exp_q.size()), 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", 64'(sample_data), 64'(e));
                n_pop++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (!reset_n) begin
            en_prev = 1'b0;
            hi_run  = 0;
            exp_q.delete();
        end else begin
            if (ro_enable && !en_prev) rise_q.push_back(cyc);
            if (ro_enable) hi_run++;
            if (!ro_enable && en_prev) begin
                hi_q.push_back(hi_run);
                hi_run = 0;
                win_idx++;
                monitor_count = 36'(win_idx * 100);
                exp_q.push_back(monitor_count);
            end
            en_prev = ro_enable;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(busy), 64'd0);
    endtask

    task automatic wait_rises(input int k, input int budget);
        int n = 0;
        while (rise_q.size() < k && n < budget) begin
            tick();
            n++;
        end
        chk("rise_timeout", 64'(rise_q.size()), 64'(k));
    endtask

    task automatic drain(input string tag);
        int n = 0;
        sample_ready = 1'b1;
        while (sample_valid && n < 40) begin
            tick();
            n++;
        end
        chk(tag, 64'(exp_q.size()), 64'd0);
    endtask

    task automatic start_run(input logic cont, input logic [WIN_W-1:0] wl, input logic [15:0] ns);
        continuous  = cont;
        window_len  = wl;
        num_samples = ns;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        continuous  = ~cont;
        window_len  = 16'd77;
        num_samples = 16'd9;
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic clear_logs();
        hi_q.delete();
        rise_q.delete();
        n_pop = 0;
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_ro_enable",    64'(ro_enable),    64'd0);
        chk("rst_ro_reset",     64'(ro_reset),     64'd1);
        chk("rst_busy",         64'(busy),         64'd0);
        chk("rst_overflow",     64'(overflow),     64'd0);
        chk("rst_sample_valid", 64'(sample_valid), 64'd0);
        chk("rst_fifo_level",   64'(fifo_level),   64'd0);
        chk("rst_sample_data",  64'(sample_data),  64'd0);
        reset_n = 1'b1;
        tick();

        // Three fixed windows of 10 clocks, values 100/200/300.
        sample_ready = 1'b1;
        clear_logs();
        start_run(1'b0, 16'd10, 16'd3);
        wait_idle(200);
        drain("t1_drain");
        chk("t1_windows", 64'(hi_q.size()), 64'd3);
        for (int i = 0; i < hi_q.size(); i++) chk("t1_enable_len", 64'(hi_q[i]), 64'd10);
        for (int i = 1; i < rise_q.size(); i++) chk("t1_period", 64'(rise_q[i] - rise_q[i-1]), 64'd19);
        chk("t1_pops", 64'(n_pop), 64'd3);
        chk("t1_valid_empty", 64'(sample_valid), 64'd0);
        chk("t1_data_hold", 64'(sample_data), 64'd300);

        // start together with stop is not a run.
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        tick();
        chk("t2_start_stop_idle", 64'(busy), 64'd0);

        // Zero window length and zero sample count both mean one.
        clear_logs();
        start_run(1'b0, 16'd0, 16'd0);
        wait_idle(100);
        drain("t2_drain");
        chk("t2_windows", 64'(hi_q.size()), 64'd1);
        if (hi_q.size() > 0) chk("t2_enable_len", 64'(hi_q[0]), 64'd1);
        chk("t2_pops", 64'(n_pop), 64'd1);

        // Continuous run, stop mid-window 5: window 5 still captured.
        clear_logs();
        start_run(1'b1, 16'd10, 16'd0);
        wait_rises(5, 200);
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(100);
        drain("t3_drain");
        chk("t3_windows", 64'(hi_q.size()), 64'd5);
        chk("t3_pops", 64'(n_pop), 64'd5);

        // Consumer stalled: FIFO fills to DEPTH, 9th and 10th captures dropped.
        clear_logs();
        sample_ready = 1'b0;
        start_run(1'b1, 16'd2, 16'd0);
        wait_rises(9, 300);
        chk("t4_level_8caps", 64'(fifo_level), 64'd8);
        chk("t4_no_ovf_yet", 64'(overflow), 64'd0);
        wait_rises(10, 100);
        chk("t4_level_9caps", 64'(fifo_level), 64'd8);
        chk("t4_ovf_set", 64'(overflow), 64'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle(100);
        if (exp_q.size() >= 2) begin
            void'(exp_q.pop_back());
            void'(exp_q.pop_back());
        end
        chk("t4_level_end", 64'(fifo_level), 64'd8);
        drain("t4_drain");
        chk("t4_pops", 64'(n_pop), 64'd8);
        chk("t4_ovf_sticky", 64'(overflow), 64'd1);

        // Full FIFO with a pop during capture: sample accepted, no overflow.
        clear_logs();
        sample_ready = 1'b0;
        start_run(1'b1, 16'd2, 16'd0);
        chk("t5_ovf_cleared", 64'(overflow), 64'd0);
        wait_rises(9, 300);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (5) tick();
        sample_ready = 1'b1;
        tick();
        sample_ready = 1'b0;
        chk("t5_level", 64'(fifo_level), 64'd8);
        chk("t5_no_ovf", 64'(overflow), 64'd0);
        chk("t5_idle", 64'(busy), 64'd0);
        drain("t5_drain");
        chk("t5_pops", 64'(n_pop), 64'd9);

        // Asynchronous reset during MEASURE, then a normal run.
        clear_logs();
        sample_ready = 1'b0;
        start_run(1'b0, 16'd10, 16'd2);
        wait_rises(2, 100);
        repeat (2) tick();
        chk("t6_level_pre", 64'(fifo_level), 64'd1);
        chk("t6_enable_pre", 64'(ro_enable), 64'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_enable_async", 64'(ro_enable), 64'd0);
        chk("t6_reset_async", 64'(ro_reset), 64'd1);
        chk("t6_level_async", 64'(fifo_level), 64'd0);
        chk("t6_busy_async", 64'(busy), 64'd0);
        chk("t6_valid_async", 64'(sample_valid), 64'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        clear_logs();
        tick();
        sample_ready = 1'b1;
        start_run(1'b0, 16'd3, 16'd1);
        wait_idle(100);
        drain("t6_drain");
        chk("t6_windows", 64'(hi_q.size()), 64'd1);
        if (hi_q.size() > 0) chk("t6_enable_len", 64'(hi_q[0]), 64'd3);
        chk("t6_pops", 64'(n_pop), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
